parking_ctrl: RTL and testbench

Occupancy and entry-barrier controller for the parking lot. It consumes the one-cycle car-passed pulses from the entry and exit sensor FSMs and keeps a saturating occupancy count. It sequences the entry barrier (open on request, close after the car passes or on timeout) and refuses entry when the lot is full. It sits between the two sensor FSMs and the barrier actuator and status display.

---
 rtl/parking_ctrl.sv | 123 ++++++++++++
 tb/tb_parking_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/parking_ctrl.sv
// Parking lot occupancy counter and entry-barrier sequencer.
// Takes one-cycle car pulses from the sensor FSMs and drives the barrier and status flags.
module parking_ctrl #(
  parameter int CAPACITY     = 8,
  parameter int CNT_W        = 4,
  parameter int OPEN_TIMEOUT = 16,
  parameter int CLOSE_DELAY  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             entry_req,
  input  logic             car_in,
  input  logic             car_out,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
  output logic             denied,
  output logic             timeout,
  output logic             tailgate,
  output logic             err_ovf,
  output logic             err_udf
);

  localparam int MAX_T = (OPEN_TIMEOUT > CLOSE_DELAY) ? OPEN_TIMEOUT : CLOSE_DELAY;
  localparam int TW    = (MAX_T > 2) ? $clog2(MAX_T) : 1;

  localparam logic [CNT_W-1:0] CAP        = CNT_W'(CAPACITY);
  localparam logic [TW-1:0]    OPEN_LAST  = TW'(OPEN_TIMEOUT - 1);
  localparam logic [TW-1:0]    CLOSE_LAST = TW'(CLOSE_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OPEN = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_reg;
  logic [TW-1:0]    timer_reg;
  logic [CNT_W-1:0] count_reg;
  logic             denied_reg;
  logic             timeout_reg;
  logic             tailgate_reg;
  logic             err_ovf_reg;
  logic             err_udf_reg;

  // Saturating occupancy count; simultaneous in/out pulses cancel regardless of level.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg   <= '0;
      err_ovf_reg <= 1'b0;
      err_udf_reg <= 1'b0;
    end else if (car_in && !car_out) begin
      if (count_reg == CAP)
        err_ovf_reg <= 1'b1;
      else
        count_reg <= count_reg + 1'b1;
    end else if (car_out && !car_in) begin
      if (count_reg == '0)
        err_udf_reg <= 1'b1;
      else
        count_reg <= count_reg - 1'b1;
    end
  end

  // Barrier sequencer; the full check uses the registered count, so a same-cycle
  // car_out cannot turn a refused request into an accepted one.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      timer_reg    <= '0;
      denied_reg   <= 1'b0;
      timeout_reg  <= 1'b0;
      tailgate_reg <= 1'b0;
    end else begin
      denied_reg   <= 1'b0;
      timeout_reg  <= 1'b0;
      tailgate_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          tailgate_reg <= car_in;
          if (entry_req) begin
            if (full) begin
              denied_reg <= 1'b1;
            end else begin
              state_reg <= OPEN;
              timer_reg <= '0;
            end
          end
        end
        OPEN: begin
          if (car_in) begin
            state_reg <= HOLD;
            timer_reg <= '0;
          end else if (timer_reg == OPEN_LAST) begin
            state_reg   <= IDLE;
            timeout_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        HOLD: begin
          if (timer_reg == CLOSE_LAST)
            state_reg <= IDLE;
          else
            timer_reg <= timer_reg + 1'b1;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign count     = count_reg;
  assign full      = (count_reg == CAP);
  assign empty     = (count_reg == '0);
  assign gate_open = (state_reg != IDLE);
  assign denied    = denied_reg;
  assign timeout   = timeout_reg;
  assign tailgate  = tailgate_reg;
  assign err_ovf   = err_ovf_reg;
  assign err_udf   = err_udf_reg;

endmodule

// File: tb/tb_parking_ctrl.sv
// Self-checking bench for parking_ctrl (default parameters, CAPACITY = 8).
// Each task pushes the expected outputs for a cycle into a queue and pops them once the DUT has clocked.
module tb_parking_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       entry_req = 1'b0;
  logic       car_in = 1'b0;
  logic       car_out = 1'b0;
  logic [3:0] count;
  logic       full, empty, gate_open, denied, timeout, tailgate, err_ovf, err_udf;

  parking_ctrl dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .car_in(car_in), .car_out(car_out),
    .count(count), .full(full), .empty(empty), .gate_open(gate_open), .denied(denied),
    .timeout(timeout), .tailgate(tailgate), .err_ovf(err_ovf), .err_udf(err_udf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       gate;
    logic [3:0] cnt;
    logic       full;
    logic       empty;
    logic       den;
    logic       to;
    logic       tg;
    logic       ovf;
    logic       udf;
  } obs_t;

  obs_t exp_q[$];
  obs_t got, want;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference occupancy state, advanced when stimulus is driven
  int   ecount = 0;
  logic eovf = 1'b0;
  logic eudf = 1'b0;

  function automatic obs_t mk(input logic g, input logic d, input logic t, input logic tg);
    obs_t r;
    r.gate  = g;
    r.cnt   = 4'(ecount);
    r.full  = (ecount == 8);
    r.empty = (ecount == 0);
    r.den   = d;
    r.to    = t;
    r.tg    = tg;
    r.ovf   = eovf;
    r.udf   = eudf;
    return r;
  endfunction

  function automatic obs_t sample();
    obs_t r;
    r = {gate_open, count, full, empty, denied, timeout, tailgate, err_ovf, err_udf};
    return r;
  endfunction

  task automatic drive(input logic r, input logic q, input logic ci, input logic co);
    reset = r; entry_req = q; car_in = ci; car_out = co;
    if (r) begin
      ecount = 0; eovf = 1'b0; eudf = 1'b0;
    end else if (ci && !co) begin
      if (ecount == 8) eovf = 1'b1; else ecount++;
    end else if (co && !ci) begin
      if (ecount == 0) eudf = 1'b1; else ecount--;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, i == 1, i == 1, 1'b0);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_reset cyc=%0d got=%b want=%b", i, got, want);
      end
    end
    $display("test_reset: %0d cycles checked", 3);
  endtask

  task automatic test_entry_car();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, i == 0, i == 3, 1'b0);
      exp_q.push_back(mk(i <= 6, 1'b0, 1'b0, 1'b0));
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_entry_car cyc=%0d got=%b want=%b", i, got, want);
      end
    end
    $display("test_entry_car: request, car 3 cycles later, count=%0d", count);
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, i == 0, 1'b0, 1'b0);
      exp_q.push_back(mk(i <= 15, 1'b0, i == 16, 1'b0));
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_timeout cyc=%0d got=%b want=%b", i, got, want);
      end
    end
    $display("test_timeout: gate open with no car, count=%0d", count);
  endtask

  task automatic test_full_deny();
    // Seven more admitted cars bring the lot to capacity
    for (int c = 0; c < 7; c++) begin
      for (int i = 0; i < 6; i++) begin
        drive(1'b0, i == 0, i == 1, 1'b0);
        exp_q.push_back(mk(i <= 4, 1'b0, 1'b0, 1'b0));
        @(posedge clk); #1;
        got = sample(); want = exp_q.pop_front(); n_checks++;
        if (got !== want) begin
          n_fail++;
          $display("FAIL test_fill car=%0d cyc=%0d got=%b want=%b", c, i, got, want);
        end
      end
      $display("test_fill: car %0d admitted, count=%0d", c, count);
    end
    // Refused while full (also with a same-cycle car_out), then admitted at 7
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, i == 0 || i == 1 || i == 3, i == 4, i == 1);
      exp_q.push_back(mk(i >= 3 && i <= 7, i <= 1, 1'b0, 1'b0));
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_full_deny cyc=%0d got=%b want=%b", i, got, want);
      end
    end
    $display("test_full_deny: denied at full, readmitted after exit, count=%0d", count);
  endtask

  task automatic test_simultaneous();
    // At count 8: cancel, drain to 0, then cancel again at 0
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, i == 0 || i == 10, i == 0 || (i >= 1 && i <= 8) || i == 10);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, i == 0 || i == 10));
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_simultaneous cyc=%0d got=%b want=%b", i, got, want);
      end
    end
    $display("test_simultaneous: in+out at 8 and at 0, count=%0d", count);
  endtask

  task automatic test_errors();
    // car_out at 0, eight tailgaters, one more car_in at 8, then idle
    for (int i = 0; i < 14; i++) begin
      drive(1'b0, 1'b0, i >= 1 && i <= 9, i == 0);
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, i >= 1 && i <= 9));
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_errors cyc=%0d got=%b want=%b", i, got, want);
      end
    end
    $display("test_errors: ovf=%0b udf=%0b count=%0d", err_ovf, err_udf, count);
  endtask

  task automatic test_reset_mid();
    // Clear, five tailgaters, open the gate, then reset while OPEN at count 5
    for (int i = 0; i < 11; i++) begin
      drive(i == 0 || i == 9, i == 6 || i == 9, (i >= 1 && i <= 5) || i == 9, 1'b0);
      exp_q.push_back(mk(i >= 6 && i <= 8, 1'b0, 1'b0, i >= 1 && i <= 5));
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_reset_mid cyc=%0d got=%b want=%b", i, got, want);
      end
    end
    $display("test_reset_mid: reset in OPEN, count=%0d gate=%0b", count, gate_open);
  endtask

  task automatic test_back_to_back();
    // Request held high across a timeout is taken as a fresh request
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      exp_q.push_back(mk(i != 16, 1'b0, i == 16, 1'b0));
      @(posedge clk); #1;
      got = sample(); want = exp_q.pop_front(); n_checks++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL test_back_to_back cyc=%0d got=%b want=%b", i, got, want);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    $display("test_back_to_back: held request reopened after timeout");
  endtask

  initial begin
    test_reset();
    test_entry_car();
    test_timeout();
    test_full_deny();
    test_simultaneous();
    test_errors();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
